// File: rtl/prog_dumper.sv
// rtl/prog_dumper.sv - program-memory read-back: fetch 16-bit words, send low/high bytes on UART TX
// tx, done and busy are registered from the current state, so they trail the FSM by one clock.
module prog_dumper #(
  parameter int CLK_DIV = 217,
  parameter int AW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_add,
  input  logic [15:0]   word_cnt,
  output logic [AW-1:0] PADD,
  output logic          rden,
  input  logic [15:0]   PDIN,
  output logic          tx,
  output logic          busy,
  output logic          done
);

  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [3:0] STOP_IDX = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    TX_LO,
    TX_HI,
    FIN
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [15:0]   rem;
  logic [15:0]   word;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    cur_byte;
  logic          frame_bit;
  logic          sending;
  logic          bit_end;
  logic          frame_end;

  always_comb begin
    sending   = (state == TX_LO) || (state == TX_HI);
    cur_byte  = (state == TX_HI) ? word[15:8] : word[7:0];
    bit_end   = (baud_cnt == '0);
    frame_end = bit_end && (bit_idx == STOP_IDX);
    frame_bit = 1'b1;
    if (bit_idx == 4'd0)
      frame_bit = 1'b0;
    else if (bit_idx < STOP_IDX)
      frame_bit = cur_byte[3'(bit_idx - 4'd1)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      PADD     <= '0;
      rden     <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr     <= '0;
      rem      <= '0;
      word     <= '0;
      baud_cnt <= BAUD_MAX;
      bit_idx  <= '0;
    end else begin
      done <= 1'b0;
      rden <= 1'b0;
      tx   <= sending ? frame_bit : 1'b1;

      if (sending) begin
        if (bit_end) begin
          baud_cnt <= BAUD_MAX;
          bit_idx  <= frame_end ? 4'd0 : bit_idx + 4'd1;
        end else begin
          baud_cnt <= baud_cnt - 1'b1;
        end
      end

      case (state)
        IDLE: begin
          // done is still high in the cycle after FIN; a start there is not taken
          if (start && !done) begin
            addr <= base_add;
            rem  <= word_cnt;
            busy <= 1'b1;
            if (word_cnt == 16'd0) begin
              state <= FIN;
            end else begin
              state <= FETCH;
              rden  <= 1'b1;
              PADD  <= base_add;
            end
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          word     <= PDIN;
          baud_cnt <= BAUD_MAX;
          bit_idx  <= '0;
          state    <= TX_LO;
        end
        TX_LO: if (frame_end) state <= TX_HI;
        TX_HI: begin
          if (frame_end) begin
            addr <= addr + 1'b1;
            rem  <= rem - 16'd1;
            if (rem == 16'd1) begin
              state <= FIN;
            end else begin
              state <= FETCH;
              rden  <= 1'b1;
              PADD  <= addr + 1'b1;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_dumper.sv
// tb/tb_prog_dumper.sv - self-checking bench for prog_dumper
module tb_prog_dumper;
  localparam int CLK_DIV = 4;
  localparam int AW = 16;
  localparam int WORD_CLKS = 20 * CLK_DIV + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] base_add = '0;
  logic [15:0] word_cnt = '0;
  logic [AW-1:0] PADD;
  logic rden;
  logic [15:0] PDIN = '0;
  logic tx, busy, done;

  logic [15:0] mem [0:65535];

  int compared = 0;
  int mismatched = 0;
  int done_seen = 0;
  logic [7:0] exp_bytes[$];
  logic [15:0] exp_addr[$];

  bit mon_active = 1'b0;
  int mon_cnt = 0;
  logic [7:0] mon_byte = '0;

  typedef struct {
    logic [15:0] base;
    logic [15:0] cnt;
    logic [2:0][15:0] w;
  } vec_t;
  vec_t vecs[5];

  prog_dumper #(.CLK_DIV(CLK_DIV), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_add(base_add), .word_cnt(word_cnt),
    .PADD(PADD), .rden(rden), .PDIN(PDIN), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rden) PDIN <= mem[PADD];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // UART receiver: samples each bit in the middle of its CLK_DIV window
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 1;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CLK_DIV) chk("start_bit_hold", {31'd0, tx}, 32'd0);
      for (int i = 0; i < 8; i++)
        if (mon_cnt == CLK_DIV * (i + 1) + CLK_DIV / 2) mon_byte[i] = tx;
      if (mon_cnt == CLK_DIV * 9 + CLK_DIV / 2) begin
        chk("stop_bit", {31'd0, tx}, 32'd1);
        if (exp_bytes.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_byte: got %h, expected none", mon_byte);
        end else begin
          chk("tx_byte", {24'd0, mon_byte}, {24'd0, exp_bytes.pop_front()});
        end
        mon_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rden) begin
      if (exp_addr.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rden: got PADD %h, expected no read", PADD);
      end else begin
        chk("padd", {16'd0, PADD}, {16'd0, exp_addr.pop_front()});
      end
    end
    if (!rst && done) done_seen++;
  end

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] c);
    @(posedge clk);
    #1;
    base_add = b;
    word_cnt = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic load_exp(input logic [15:0] base, input logic [15:0] cnt, input logic [2:0][15:0] w);
    logic [15:0] a;
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 16'(i);
      mem[a] = w[i];
      exp_addr.push_back(a);
      exp_bytes.push_back(w[i][7:0]);
      exp_bytes.push_back(w[i][15:8]);
    end
  endtask

  task automatic run_xfer(input logic [15:0] base, input logic [15:0] cnt, input logic [2:0][15:0] w);
    int d0;
    bit ok;
    load_exp(base, cnt, w);
    d0 = done_seen;
    pulse_start(base, cnt);
    wait_done(int'(cnt) * WORD_CLKS + 20, ok);
    chk("done_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("done_count", 32'(done_seen - d0), 32'd1);
    chk("bytes_left", 32'(exp_bytes.size()), 32'd0);
    chk("addrs_left", 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit ok;
    vecs[0] = '{base: 16'h0010, cnt: 16'd1, w: {16'h0000, 16'h0000, 16'hA55A}};
    vecs[1] = '{base: 16'hFFFE, cnt: 16'd3, w: {16'h3333, 16'h2222, 16'h1111}};
    vecs[2] = '{base: 16'h0100, cnt: 16'd2, w: {16'h0000, 16'hFFFF, 16'h0000}};
    vecs[3] = '{base: 16'h1234, cnt: 16'd0, w: {16'h0000, 16'h0000, 16'hDEAD}};
    vecs[4] = '{base: 16'h4000, cnt: 16'd3, w: {16'h0F0F, 16'h8001, 16'h7E81}};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_padd", {16'd0, PADD}, 32'd0);
    chk("rst_rden", {31'd0, rden}, 32'd0);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) run_xfer(vecs[v].base, vecs[v].cnt, vecs[v].w);

    // first-word latency and overall word length
    load_exp(16'h0200, 16'd1, {16'h0, 16'h0, 16'h3CC3});
    pulse_start(16'h0200, 16'd1);
    chk("t0_busy", {31'd0, busy}, 32'd1);
    chk("t0_rden", {31'd0, rden}, 32'd1);
    chk("t0_padd", {16'd0, PADD}, 32'h0200);
    chk("t0_tx", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    chk("t1_rden", {31'd0, rden}, 32'd0);
    chk("t1_tx", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    chk("t2_tx", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    chk("t3_tx_first_low", {31'd0, tx}, 32'd0);
    repeat (20 * CLK_DIV - 1) @(posedge clk);
    #1;
    chk("done_early", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("done_at_stop_end", {31'd0, done}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("tx_idle_at_done", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // cnt=0 timing
    pulse_start(16'h0AAA, 16'd0);
    chk("z0_busy", {31'd0, busy}, 32'd1);
    chk("z0_done", {31'd0, done}, 32'd0);
    chk("z0_rden", {31'd0, rden}, 32'd0);
    @(posedge clk); #1;
    chk("z1_done", {31'd0, done}, 32'd1);
    chk("z1_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("z2_done", {31'd0, done}, 32'd0);
    chk("z2_tx", {31'd0, tx}, 32'd1);

    // start re-pulsed while the low byte is on the line
    load_exp(16'h0300, 16'd1, {16'h0, 16'h0, 16'h6E91});
    d0 = done_seen;
    pulse_start(16'h0300, 16'd1);
    repeat (10) @(posedge clk);
    pulse_start(16'h0400, 16'd2);
    wait_done(WORD_CLKS + 20, ok);
    chk("rp_done_timeout", {31'd0, ok}, 32'd1);
    repeat (3 * WORD_CLKS) @(posedge clk);
    #1;
    chk("rp_done_count", 32'(done_seen - d0), 32'd1);
    chk("rp_bytes_left", 32'(exp_bytes.size()), 32'd0);

    // start presented in the done cycle is dropped
    load_exp(16'h0500, 16'd1, {16'h0, 16'h0, 16'hC35A});
    d0 = done_seen;
    pulse_start(16'h0500, 16'd1);
    wait_done(WORD_CLKS + 20, ok);
    chk("dc_done_timeout", {31'd0, ok}, 32'd1);
    base_add = 16'h0600;
    word_cnt = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("dc_done_count", 32'(done_seen - d0), 32'd1);
    chk("dc_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of a start bit, then a clean transfer
    load_exp(16'h0700, 16'd1, {16'h0, 16'h0, 16'h55AA});
    d0 = done_seen;
    pulse_start(16'h0700, 16'd1);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rs_start_seen", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rs_tx", {31'd0, tx}, 32'd1);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    exp_bytes.delete();
    exp_addr.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("rs_no_done", 32'(done_seen - d0), 32'd0);
    run_xfer(16'h0800, 16'd1, {16'h0, 16'h0, 16'h9C63});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
